// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
//   XLEN          default address width
//   INSTR_W       instruction width
//   RISCV_NOP     canonical NOP encoding (addi x0,x0,0)
//   fetch_entry_t one queue entry {pc, instr} at the default width
package fetch_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] RISCV_NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/superscalar_fetch_if.sv
// Bundle of the fetch unit's memory-side and decode-side signals.
//   master : fetch unit (drives PC/PC4, queue outputs, fetch_stall)
//   slave  : memory + decode environment (drives instr pair, redirect, deq_cnt)
interface superscalar_fetch_if #(
  parameter int XLEN = 64
);
  import fetch_pkg::*;

  // instruction memory side
  logic [XLEN-1:0]    PC;
  logic [XLEN-1:0]    PC4;
  logic [INSTR_W-1:0] instr1;
  logic [INSTR_W-1:0] instr2;

  // decode / branch side
  logic               redirect_en;
  logic [XLEN-1:0]    redirect_pc;
  logic [1:0]         deq_cnt;
  logic               out0_valid;
  logic [XLEN-1:0]    out0_pc;
  logic [INSTR_W-1:0] out0_instr;
  logic               out1_valid;
  logic [XLEN-1:0]    out1_pc;
  logic [INSTR_W-1:0] out1_instr;
  logic               fetch_stall;

  modport master (
    output PC, PC4, out0_valid, out0_pc, out0_instr,
           out1_valid, out1_pc, out1_instr, fetch_stall,
    input  instr1, instr2, redirect_en, redirect_pc, deq_cnt
  );

  modport slave (
    input  PC, PC4, out0_valid, out0_pc, out0_instr,
           out1_valid, out1_pc, out1_instr, fetch_stall,
    output instr1, instr2, redirect_en, redirect_pc, deq_cnt
  );

endinterface

// File: rtl/fetch_queue.sv
// 2-write / 2-read circular FIFO of fetch entries.
//   clk, rst_n     clock, asynchronous active-low reset (clears storage too)
//   flush          empties the queue (pointers and count to 0), highest priority
//   enq            write wr0 at tail and wr1 at tail+1; caller guarantees room
//   wr0, wr1       entries to write
//   deq_req        0..2 entries consumed from head; clamped to count
//   count          current occupancy 0..DEPTH
//   head0, head1   storage at head and head+1 (shown regardless of occupancy)
module fetch_queue #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_pkg::fetch_entry_t
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 enq,
  input  entry_t               wr0,
  input  entry_t               wr1,
  input  logic [1:0]           deq_req,
  output logic [$clog2(DEPTH):0] count,
  output entry_t               head0,
  output entry_t               head1
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_reg [DEPTH];
  logic [PW-1:0]   head_reg;
  logic [PW-1:0]   tail_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   head1_ptr;
  logic [PW-1:0]   tail1_ptr;
  logic [CW-1:0]   deq_eff;
  logic [DEPTH-1:0] wr0_sel;
  logic [DEPTH-1:0] wr1_sel;

  // Pointers are exactly PW bits wide, so +1 / +2 wrap modulo DEPTH for free.
  assign head1_ptr = head_reg + PW'(1);
  assign tail1_ptr = tail_reg + PW'(1);

  // Asking for more than is present is a decode protocol error; never underflow.
  assign deq_eff = (CW'(deq_req) > count_reg) ? count_reg : CW'(deq_req);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_sel
    assign wr0_sel[gi] = enq && (tail_reg  == PW'(gi));
    assign wr1_sel[gi] = enq && (tail1_ptr == PW'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PW'(deq_eff);
      if (enq) tail_reg <= tail_reg + PW'(2);
      count_reg <= count_reg - deq_eff + (enq ? CW'(2) : CW'(0));
      for (int i = 0; i < DEPTH; i++) begin
        if (wr0_sel[i])      mem_reg[i] <= wr0;
        else if (wr1_sel[i]) mem_reg[i] <= wr1;
      end
    end
  end

  assign count = count_reg;
  assign head0 = mem_reg[head_reg];
  assign head1 = mem_reg[head1_ptr];

endmodule

// File: rtl/superscalar_fetch.sv
// Dual-issue fetch front end: PC register, pair fetch into a small queue,
// in-order presentation of up to two instructions per cycle to decode.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         superscalar_fetch_if.master: PC/PC4 and instr1/instr2 to/from
//               memory; redirect_en/redirect_pc, deq_cnt from decode/branch;
//               out0_*/out1_* queue head entries and fetch_stall to decode
module superscalar_fetch #(
  parameter int              XLEN     = 64,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  superscalar_fetch_if.master  bus
);
  import fetch_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;

  // Same layout as fetch_entry_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_reg;
  logic [CW-1:0]   count;
  logic            enq;
  entry_t          wr0;
  entry_t          wr1;
  entry_t          head0;
  entry_t          head1;
  logic            unused_redirect_lsbs;

  // Only the registered count decides whether there is room, which keeps
  // deq_cnt off the path to PC and fetch_stall.
  assign enq = !bus.redirect_en && (count <= CW'(QDEPTH - 2));

  assign bus.PC          = pc_reg;
  assign bus.PC4         = pc_reg + XLEN'(4);
  assign bus.fetch_stall = !enq;

  assign wr0 = '{pc: pc_reg,  instr: bus.instr1};
  assign wr1 = '{pc: bus.PC4, instr: bus.instr2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               pc_reg <= RESET_PC;
    else if (bus.redirect_en) pc_reg <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    else if (enq)             pc_reg <= pc_reg + XLEN'(8);
  end

  // Redirect target is word aligned; the low bits carry no information.
  assign unused_redirect_lsbs = &{1'b0, bus.redirect_pc[1:0]};

  fetch_queue #(
    .DEPTH   (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.redirect_en),
    .enq     (enq),
    .wr0     (wr0),
    .wr1     (wr1),
    .deq_req (bus.deq_cnt),
    .count   (count),
    .head0   (head0),
    .head1   (head1)
  );

  assign bus.out0_valid = (count != '0);
  assign bus.out1_valid = (count >= CW'(2));
  assign bus.out0_pc    = head0.pc;
  assign bus.out0_instr = head0.instr;
  assign bus.out1_pc    = head1.pc;
  assign bus.out1_instr = head1.instr;

endmodule
